// File: rtl/dcmac_seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcmac_seg_pkg : DCMAC segment types and tkeep helpers (shared TX/RX)
// Revision      : 1.0
// ---------------------------------------------------------------------------
package dcmac_seg_pkg;

    localparam int SEG_BYTES  = 16;
    localparam int SEG_DATA_W = 128;
    localparam int MTY_W      = 4;
    localparam int MAX_SEGS   = 4;
    localparam int MAX_KEEP_W = SEG_BYTES * MAX_SEGS;

    typedef struct packed {
        logic [SEG_DATA_W-1:0] data;
        logic                  ena;
        logic                  sop;
        logic                  eop;
        logic [MTY_W-1:0]      mty;
        logic                  err;
    } seg_t;

    typedef enum logic [0:0] {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_t;

    // Empty-byte count of one segment; a fully empty segment wraps to 0.
    function automatic logic [MTY_W-1:0] keep_to_mty(input logic [SEG_BYTES-1:0] keep);
        logic [4:0] ones;
        logic [4:0] empty;
        ones = '0;
        for (int i = 0; i < SEG_BYTES; i++) begin
            ones = ones + 5'(keep[i]);
        end
        empty = 5'd16 - ones;
        return empty[MTY_W-1:0];
    endfunction

    // True when set bits form one run starting at bit 0 (zero counts as contiguous).
    function automatic logic keep_contiguous(input logic [MAX_KEEP_W-1:0] keep);
        logic [MAX_KEEP_W-1:0] plus1;
        plus1 = keep + MAX_KEEP_W'(1);
        return (keep & plus1) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_to_dcmac_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_to_dcmac_if : AXI-stream input bus of SEG_COUNT x 128-bit segments
// Revision         : 1.0
// ---------------------------------------------------------------------------
interface axis_to_dcmac_if
    import dcmac_seg_pkg::*;
#(
    parameter int SEG_COUNT = 2
);
    logic [SEG_DATA_W*SEG_COUNT-1:0] tdata;
    logic [SEG_BYTES*SEG_COUNT-1:0]  tkeep;
    logic [1:0]                      tuser;
    logic                            tlast;
    logic                            tvalid;
    logic                            tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_skid_buffer : 2-entry skid with registered ready; head entry is a register
// Revision         : 1.0
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             push_valid,
    output logic                  push_ready,
    output logic [WIDTH-1:0]      head_data,
    input  wire logic             pop
);
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_spare;
    logic [1:0]       r_count;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_push     = push_valid & r_ready;
    assign w_pop      = pop & (r_count != 2'd0);
    assign push_ready = r_ready;
    assign head_data  = r_head;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Ready is derived from the next count, so a push never lands on a full buffer;
    // an emptied head is cleared so the outputs read as idle zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_spare <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < 2'd2);
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head  <= r_spare;
                    r_spare <= '0;
                end else if (w_push) begin
                    r_head <= push_data;
                end else begin
                    r_head <= '0;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= push_data;
                end else begin
                    r_spare <= push_data;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/axis_to_dcmac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_to_dcmac : splits AXI-stream beats into registered DCMAC TX segments
// Revision      : 1.0
// ---------------------------------------------------------------------------
module axis_to_dcmac
    import dcmac_seg_pkg::*;
#(
    parameter int SEG_COUNT = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    axis_to_dcmac_if.slave   axis_in,
    output logic [127:0]     o_seg0_tdata,
    output logic             o_seg0_ena,
    output logic             o_seg0_sop,
    output logic             o_seg0_eop,
    output logic [3:0]       o_seg0_mty,
    output logic             o_seg0_err,
    output logic [127:0]     o_seg1_tdata,
    output logic             o_seg1_ena,
    output logic             o_seg1_sop,
    output logic             o_seg1_eop,
    output logic [3:0]       o_seg1_mty,
    output logic             o_seg1_err,
    output logic [127:0]     o_seg2_tdata,
    output logic             o_seg2_ena,
    output logic             o_seg2_sop,
    output logic             o_seg2_eop,
    output logic [3:0]       o_seg2_mty,
    output logic             o_seg2_err,
    output logic [127:0]     o_seg3_tdata,
    output logic             o_seg3_ena,
    output logic             o_seg3_sop,
    output logic             o_seg3_eop,
    output logic [3:0]       o_seg3_mty,
    output logic             o_seg3_err,
    input  wire logic        i_tx_tready,
    output logic [15:0]      o_malformed_cnt
);
    localparam int SEG_W = $bits(seg_t);

    generate
        if (SEG_COUNT != 2 && SEG_COUNT != 4) begin : g_bad_seg_count
            $error("axis_to_dcmac: SEG_COUNT must be 2 or 4");
        end
    endgenerate

    pkt_state_t             r_state;
    pkt_state_t             w_state_nxt;
    logic [15:0]            r_malformed_cnt;
    seg_t [SEG_COUNT-1:0]   w_fmt;
    seg_t [SEG_COUNT-1:0]   w_head;
    seg_t [MAX_SEGS-1:0]    w_out;
    logic [SEG_COUNT-1:0]   w_ena;
    int                     w_last_seg;
    logic                   w_keep_zero;
    logic                   w_keep_full;
    logic                   w_malformed;
    logic                   w_emit;
    logic                   w_accept;
    logic                   w_skid_ready;

    assign w_keep_zero = (axis_in.tkeep == '0);
    assign w_keep_full = &axis_in.tkeep;
    assign w_malformed = !keep_contiguous(MAX_KEEP_W'(axis_in.tkeep))
                       || (!axis_in.tlast && !w_keep_full)
                       || w_keep_zero;
    // An empty non-last beat carries nothing and is swallowed at the input.
    assign w_emit      = !(w_keep_zero && !axis_in.tlast);
    assign w_accept    = axis_in.tvalid & w_skid_ready;
    assign axis_in.tready = w_skid_ready;

    // Segment formatter works on the input beat so the skid head is the output register.
    always_comb begin
        w_ena      = '0;
        w_last_seg = 0;
        w_fmt      = '0;
        for (int k = 0; k < SEG_COUNT; k++) begin
            w_ena[k] = axis_in.tkeep[SEG_BYTES*k];
        end
        if (w_keep_zero && axis_in.tlast) begin
            w_ena[0] = 1'b1;
        end
        for (int k = 0; k < SEG_COUNT; k++) begin
            if (w_ena[k]) begin
                w_last_seg = k;
            end
        end
        for (int k = 0; k < SEG_COUNT; k++) begin
            w_fmt[k].ena  = w_ena[k];
            w_fmt[k].data = w_ena[k] ? axis_in.tdata[SEG_DATA_W*k +: SEG_DATA_W] : '0;
            w_fmt[k].sop  = (k == 0) && (r_state == PKT_IDLE) && w_ena[k];
            w_fmt[k].eop  = axis_in.tlast && w_ena[k] && (k == w_last_seg);
            w_fmt[k].mty  = w_fmt[k].eop ? keep_to_mty(axis_in.tkeep[SEG_BYTES*k +: SEG_BYTES]) : '0;
            w_fmt[k].err  = w_fmt[k].eop && ((|axis_in.tuser) || w_keep_zero);
        end
    end

    axis_skid_buffer #(
        .WIDTH (SEG_W*SEG_COUNT)
    ) u_skid (
        .clk        (clk),
        .rst        (reset),
        .push_data  (w_fmt),
        .push_valid (axis_in.tvalid & w_emit),
        .push_ready (w_skid_ready),
        .head_data  (w_head),
        .pop        (i_tx_tready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PKT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = axis_in.tlast ? PKT_IDLE : PKT_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_malformed_cnt <= '0;
        end else if (w_accept && w_malformed && (r_malformed_cnt != 16'hFFFF)) begin
            r_malformed_cnt <= r_malformed_cnt + 16'd1;
        end
    end

    assign o_malformed_cnt = r_malformed_cnt;

    generate
        for (genvar k = 0; k < MAX_SEGS; k++) begin : g_out
            if (k < SEG_COUNT) begin : g_live
                assign w_out[k] = w_head[k];
            end else begin : g_tie
                assign w_out[k] = '0;
            end
        end
    endgenerate

    assign o_seg0_tdata = w_out[0].data;
    assign o_seg0_ena   = w_out[0].ena;
    assign o_seg0_sop   = w_out[0].sop;
    assign o_seg0_eop   = w_out[0].eop;
    assign o_seg0_mty   = w_out[0].mty;
    assign o_seg0_err   = w_out[0].err;
    assign o_seg1_tdata = w_out[1].data;
    assign o_seg1_ena   = w_out[1].ena;
    assign o_seg1_sop   = w_out[1].sop;
    assign o_seg1_eop   = w_out[1].eop;
    assign o_seg1_mty   = w_out[1].mty;
    assign o_seg1_err   = w_out[1].err;
    assign o_seg2_tdata = w_out[2].data;
    assign o_seg2_ena   = w_out[2].ena;
    assign o_seg2_sop   = w_out[2].sop;
    assign o_seg2_eop   = w_out[2].eop;
    assign o_seg2_mty   = w_out[2].mty;
    assign o_seg2_err   = w_out[2].err;
    assign o_seg3_tdata = w_out[3].data;
    assign o_seg3_ena   = w_out[3].ena;
    assign o_seg3_sop   = w_out[3].sop;
    assign o_seg3_eop   = w_out[3].eop;
    assign o_seg3_mty   = w_out[3].mty;
    assign o_seg3_err   = w_out[3].err;
endmodule
`default_nettype wire

// File: tb/tb_axis_to_dcmac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_to_dcmac : directed bench for SEG_COUNT=2 and SEG_COUNT=4 instances
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_axis_to_dcmac;
    logic clk = 1'b0;
    logic reset;
    logic tx_rdy2;
    logic tx_rdy4;
    int   errors = 0;
    int   checks = 0;
    int   nsent;
    int   ndel;
    logic hs;

    always #5 clk = ~clk;

    axis_to_dcmac_if #(.SEG_COUNT(2)) a2 ();
    axis_to_dcmac_if #(.SEG_COUNT(4)) a4 ();

    wire [3:0][127:0] d2_data, d4_data;
    wire [3:0]        d2_ena, d2_sop, d2_eop, d2_err;
    wire [3:0]        d4_ena, d4_sop, d4_eop, d4_err;
    wire [3:0][3:0]   d2_mty, d4_mty;
    wire [15:0]       cnt2, cnt4;

    axis_to_dcmac #(.SEG_COUNT(2)) dut2 (
        .clk(clk), .reset(reset), .axis_in(a2),
        .o_seg0_tdata(d2_data[0]), .o_seg0_ena(d2_ena[0]), .o_seg0_sop(d2_sop[0]),
        .o_seg0_eop(d2_eop[0]), .o_seg0_mty(d2_mty[0]), .o_seg0_err(d2_err[0]),
        .o_seg1_tdata(d2_data[1]), .o_seg1_ena(d2_ena[1]), .o_seg1_sop(d2_sop[1]),
        .o_seg1_eop(d2_eop[1]), .o_seg1_mty(d2_mty[1]), .o_seg1_err(d2_err[1]),
        .o_seg2_tdata(d2_data[2]), .o_seg2_ena(d2_ena[2]), .o_seg2_sop(d2_sop[2]),
        .o_seg2_eop(d2_eop[2]), .o_seg2_mty(d2_mty[2]), .o_seg2_err(d2_err[2]),
        .o_seg3_tdata(d2_data[3]), .o_seg3_ena(d2_ena[3]), .o_seg3_sop(d2_sop[3]),
        .o_seg3_eop(d2_eop[3]), .o_seg3_mty(d2_mty[3]), .o_seg3_err(d2_err[3]),
        .i_tx_tready(tx_rdy2), .o_malformed_cnt(cnt2)
    );

    axis_to_dcmac #(.SEG_COUNT(4)) dut4 (
        .clk(clk), .reset(reset), .axis_in(a4),
        .o_seg0_tdata(d4_data[0]), .o_seg0_ena(d4_ena[0]), .o_seg0_sop(d4_sop[0]),
        .o_seg0_eop(d4_eop[0]), .o_seg0_mty(d4_mty[0]), .o_seg0_err(d4_err[0]),
        .o_seg1_tdata(d4_data[1]), .o_seg1_ena(d4_ena[1]), .o_seg1_sop(d4_sop[1]),
        .o_seg1_eop(d4_eop[1]), .o_seg1_mty(d4_mty[1]), .o_seg1_err(d4_err[1]),
        .o_seg2_tdata(d4_data[2]), .o_seg2_ena(d4_ena[2]), .o_seg2_sop(d4_sop[2]),
        .o_seg2_eop(d4_eop[2]), .o_seg2_mty(d4_mty[2]), .o_seg2_err(d4_err[2]),
        .o_seg3_tdata(d4_data[3]), .o_seg3_ena(d4_ena[3]), .o_seg3_sop(d4_sop[3]),
        .o_seg3_eop(d4_eop[3]), .o_seg3_mty(d4_mty[3]), .o_seg3_err(d4_err[3]),
        .i_tx_tready(tx_rdy4), .o_malformed_cnt(cnt4)
    );

    task automatic check(input string tag, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(input logic [255:0] data, input logic [31:0] keep,
                         input logic last, input logic [1:0] user);
        a2.tvalid = 1'b1;
        a2.tdata  = data;
        a2.tkeep  = keep;
        a2.tlast  = last;
        a2.tuser  = user;
    endtask

    task automatic idle2();
        a2.tvalid = 1'b0;
        a2.tdata  = '0;
        a2.tkeep  = '0;
        a2.tlast  = 1'b0;
        a2.tuser  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        tx_rdy2 = 1'b1;
        tx_rdy4 = 1'b1;
        idle2();
        a4.tvalid = 1'b0;
        a4.tdata  = '0;
        a4.tkeep  = '0;
        a4.tlast  = 1'b0;
        a4.tuser  = '0;
        repeat (3) step();

        // Reset state
        check("rst_tready", a2.tready === 1'b0);
        check("rst_ena", d2_ena === 4'b0000);
        check("rst_data0", d2_data[0] === 128'h0);
        check("rst_cnt", cnt2 === 16'h0);
        reset = 1'b0;
        step();
        check("post_rst_tready", a2.tready === 1'b1);

        // 64-byte packet, two full beats
        beat2({128'h0B01, 128'h0B00}, 32'hFFFF_FFFF, 1'b0, 2'b00);
        step();
        beat2({128'h0B11, 128'h0B10}, 32'hFFFF_FFFF, 1'b1, 2'b00);
        check("t1_b0_data0", d2_data[0] === 128'h0B00);
        check("t1_b0_ena", d2_ena === 4'b0011);
        check("t1_b0_sop", d2_sop === 4'b0001);
        check("t1_b0_eop", d2_eop === 4'b0000);
        step();
        idle2();
        check("t1_b1_data1", d2_data[1] === 128'h0B11);
        check("t1_b1_sop", d2_sop === 4'b0000);
        check("t1_b1_eop", d2_eop === 4'b0010);
        check("t1_b1_mty1", d2_mty[1] === 4'd0);
        check("t1_b1_err", d2_err === 4'b0000);
        step();
        check("t1_idle_ena", d2_ena === 4'b0000);
        check("t1_idle_data0", d2_data[0] === 128'h0);

        // 65-byte packet, then a single-beat packet to confirm return to IDLE
        beat2({128'h0C01, 128'h0C00}, 32'hFFFF_FFFF, 1'b0, 2'b00);
        step();
        check("t2_b0_sop", d2_sop === 4'b0001);
        beat2({128'h0C11, 128'h0C10}, 32'hFFFF_FFFF, 1'b0, 2'b00);
        step();
        check("t2_b1_sop", d2_sop === 4'b0000);
        beat2({128'h0C21, 128'h0C20}, 32'h0000_0001, 1'b1, 2'b00);
        step();
        beat2({128'h0D01, 128'h0D00}, 32'h0000_FFFF, 1'b1, 2'b00);
        check("t2_b2_ena", d2_ena === 4'b0001);
        check("t2_b2_eop", d2_eop === 4'b0001);
        check("t2_b2_mty0", d2_mty[0] === 4'd15);
        check("t2_b2_data0", d2_data[0] === 128'h0C20);
        check("t2_b2_err", d2_err === 4'b0000);
        step();
        idle2();
        check("t2_single_sop", d2_sop === 4'b0001);
        check("t2_single_eop", d2_eop === 4'b0001);
        check("t2_single_ena", d2_ena === 4'b0001);
        check("t2_single_mty0", d2_mty[0] === 4'd0);
        step();

        // Backpressure: 5 stalled cycles with tvalid held high
        nsent = 0;
        ndel  = 0;
        for (int c = 0; c < 40 && ndel < 4; c++) begin
            tx_rdy2 = (c >= 5);
            if (nsent < 4) begin
                beat2({128'(32'hE100 + nsent), 128'(32'hE000 + nsent)}, 32'hFFFF_FFFF,
                      nsent == 3, 2'b00);
            end else begin
                idle2();
            end
            if (d2_ena[0] && tx_rdy2) begin
                check("t3_order", d2_data[0] === 128'(32'hE000 + ndel));
                check("t3_eop1", d2_eop[1] === (ndel == 3));
                ndel++;
            end
            hs = a2.tvalid && a2.tready;
            step();
            if (hs) nsent++;
            if (c == 4) begin
                check("t3_accepted", nsent === 2);
                check("t3_tready_low", a2.tready === 1'b0);
                check("t3_hold_data0", d2_data[0] === 128'hE000);
                check("t3_hold_sop", d2_sop === 4'b0001);
            end
        end
        check("t3_delivered", ndel === 4);
        tx_rdy2 = 1'b1;
        idle2();
        step();

        // SEG_COUNT=4, 40-byte bad packet in one beat
        a4.tvalid = 1'b1;
        a4.tdata  = {128'h0, 128'h0F02, 128'h0F01, 128'h0F00};
        a4.tkeep  = 64'h0000_00FF_FFFF_FFFF;
        a4.tlast  = 1'b1;
        a4.tuser  = 2'b01;
        step();
        a4.tvalid = 1'b0;
        check("t4_ena", d4_ena === 4'b0111);
        check("t4_sop", d4_sop === 4'b0001);
        check("t4_eop", d4_eop === 4'b0100);
        check("t4_mty2", d4_mty[2] === 4'd8);
        check("t4_err", d4_err === 4'b0100);
        check("t4_data2", d4_data[2] === 128'h0F02);
        check("t4_cnt", cnt4 === 16'd0);
        step();

        // Malformed beats: partial non-last, then empty last
        check("t5_cnt_before", cnt2 === 16'd0);
        beat2({128'h0A01, 128'h0A00}, 32'h00FF_FFFF, 1'b0, 2'b00);
        step();
        beat2({128'h0A11, 128'h0A10}, 32'h0000_0000, 1'b1, 2'b00);
        check("t5_a_ena", d2_ena === 4'b0011);
        check("t5_a_sop", d2_sop === 4'b0001);
        check("t5_a_eop", d2_eop === 4'b0000);
        check("t5_a_cnt", cnt2 === 16'd1);
        step();
        idle2();
        check("t5_b_ena", d2_ena === 4'b0001);
        check("t5_b_sop", d2_sop === 4'b0000);
        check("t5_b_eop", d2_eop === 4'b0001);
        check("t5_b_err", d2_err === 4'b0001);
        check("t5_b_mty0", d2_mty[0] === 4'd0);
        check("t5_b_cnt", cnt2 === 16'd2);
        step();

        // Empty non-last beat is dropped but still moves the packet out of IDLE
        beat2(256'h0, 32'h0000_0000, 1'b0, 2'b00);
        step();
        beat2({128'h0711, 128'h0710}, 32'hFFFF_FFFF, 1'b1, 2'b00);
        check("t5_drop_ena", d2_ena === 4'b0000);
        check("t5_drop_cnt", cnt2 === 16'd3);
        step();
        idle2();
        check("t5_after_drop_sop", d2_sop === 4'b0000);
        check("t5_after_drop_eop", d2_eop === 4'b0010);
        check("t5_after_drop_cnt", cnt2 === 16'd3);
        step();

        // Reset with two beats buffered
        tx_rdy2 = 1'b0;
        beat2({128'h0601, 128'h0600}, 32'hFFFF_FFFF, 1'b0, 2'b00);
        step();
        beat2({128'h0611, 128'h0610}, 32'hFFFF_FFFF, 1'b0, 2'b00);
        step();
        idle2();
        check("t6_full_tready", a2.tready === 1'b0);
        check("t6_full_data0", d2_data[0] === 128'h0600);
        reset = 1'b1;
        step();
        check("t6_rst_ena", d2_ena === 4'b0000);
        check("t6_rst_cnt", cnt2 === 16'd0);
        check("t6_rst_data0", d2_data[0] === 128'h0);
        check("t6_rst_tready", a2.tready === 1'b0);
        reset   = 1'b0;
        tx_rdy2 = 1'b1;
        step();
        check("t6_tready", a2.tready === 1'b1);
        beat2({128'h0501, 128'h0500}, 32'h0000_FFFF, 1'b1, 2'b00);
        step();
        idle2();
        check("t6_sop", d2_sop === 4'b0001);
        check("t6_eop", d2_eop === 4'b0001);
        check("t6_data0", d2_data[0] === 128'h0500);
        step();
        check("t6_idle_ena", d2_ena === 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
